// File: rtl/set_bit_ser_pkg.sv
// ============================================================================
// Module  : set_bit_ser_pkg
// Brief   : Shared types and helpers for the set-bit serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package set_bit_ser_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_IDX_W = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Narrower vectors are zero-extended by the caller; the result is then truncated.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_W-1:0] onehot);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (onehot[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsb_select.sv
// ============================================================================
// Module  : lsb_select
// Brief   : Isolates the lowest set bit of a vector, its index and a
//           single-bit-set flag. Supports WIDTH from 2 to 64.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsb_select
  import set_bit_ser_pkg::*;
#(
  parameter int  WIDTH = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  logic [MAX_W-1:0] onehot_ext;

  // Two's-complement trick: vec & -vec keeps only the rightmost set bit.
  assign onehot = vec & (~vec + WIDTH'(1));
  assign single = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

  always_comb begin
    onehot_ext              = '0;
    onehot_ext[WIDTH-1:0]   = onehot;
  end

  assign idx = IDX_W'(onehot_to_idx(onehot_ext));

endmodule

`default_nettype wire

// File: rtl/set_bit_serializer.sv
// ============================================================================
// Module  : set_bit_serializer
// Brief   : Emits each set bit of an accepted word as a one-hot beat, LSB
//           first, with valid/ready handshakes on both sides.
// Revision: 1.0
// ============================================================================
`default_nettype none

module set_bit_serializer
  import set_bit_ser_pkg::*;
#(
  parameter int  WIDTH = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] bit_o,
  output logic [IDX_W-1:0] bit_idx_o,
  output logic             bit_last_o,
  output logic             bit_val_o,
  input  logic             bit_ready_i
);

  state_t           state;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sel_onehot;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_single;
  logic             accept;
  logic             take;
  logic             busy;

  lsb_select #(
    .WIDTH (WIDTH)
  ) u_lsb_select (
    .vec    (res),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .single (sel_single)
  );

  assign busy       = (state == SHIFT);
  assign bit_val_o  = busy;
  assign bit_o      = busy ? sel_onehot : '0;
  assign bit_idx_o  = busy ? sel_idx    : '0;
  assign bit_last_o = busy & sel_single;

  assign take         = bit_val_o & bit_ready_i;
  // Reopening on the last take lets the next word follow with no bubble.
  assign data_ready_o = ~busy | (take & bit_last_o);
  assign accept       = data_val_i & data_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (data_i != '0)) begin
            res   <= data_i;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (take) begin
            if (!bit_last_o) begin
              res <= res & ~sel_onehot;
            end else if (accept && (data_i != '0)) begin
              res <= data_i;
            end else begin
              res   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          res   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
